dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the 1024 x 64-bit data memory (byte write enables, 1-cycle read latency) behind the mem stage. It shares the single dmem port between the pipeline mem stage (port P) and an external requester (port E: program loader or display fetch). Port P has priority, and port E is protected from starvation by a wait counter. P is stalled while it loses arbitration, and read data returns to the winning port one cycle after grant.

## Interface
- STARVE_LIMIT, 4: consecutive cycles E may wait while requesting before it gets forced priority; legal range 1..15
- sys_clk  in  1  clock, all state on rising edge
- sys_rst  in  1  synchronous, active-high reset
- p_req  in  1  pipeline access request
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  13  pipeline byte address
- p_width  in  8  unshifted byte mask (0x01/0x03/0x0F/0xFF)
- p_wdata  in  64  pipeline write data, already lane-aligned
- p_stall  out  1  p_req && !p_gnt
- p_gnt  out  1  pipeline access issued this cycle
- p_rvalid  out  1  pipeline read data valid
- p_rdata  out  64  pipeline read data
- e_req, e_we, e_addr[12:0], e_width[7:0], e_wdata[63:0]  in  external port; same meaning as the pipeline inputs
- e_gnt, e_rvalid, e_rdata[63:0]  out  external port; same meaning as the pipeline outputs
- dm_ena  out  1  dmem enable
- dm_wea  out  8  dmem byte write enables
- dm_addra  out  10  dmem word address
- dm_dina  out  64  dmem write data
- dm_douta  in  64  dmem read data, valid the cycle after the read

## Operation
- Priority FSM, 2 states:
  - P_PRI (reset state): P wins whenever p_req.
    - wait_cnt (4 bit) increments each cycle that e_req && !e_gnt.
    - Enter E_PRI at the clock edge where the increment would reach STARVE_LIMIT.
    - wait_cnt clears whenever e_gnt or !e_req.
  - E_PRI: E wins if e_req; otherwise P wins if p_req. The next state is always P_PRI, and wait_cnt clears.
- Grant is combinational in the cycle of the access. At most one gnt per cycle. No grant when neither port requests.
- Issued access:
  - dm_ena=1.
  - dm_addra=addr[12:3].
  - dm_dina=wdata, passed unshifted.
  - dm_wea = we ? (width << addr[2:0]) truncated to 8 bits : 8'h00.
- With no grant, all dm_* outputs are 0.
- Reads: a 1-bit source tag and a valid flag are registered at grant.
  - In the next cycle, the tagged port's rvalid=1 and its rdata=dm_douta.
  - The other port's rdata holds its last value.
- Writes never produce rvalid.
- Address bits [2:0] are ignored for the dmem word index. A misaligned mask that shifts out of bit 7 is truncated and not wrapped.

## Timing
- Access latency after grant: 0 cycles for dmem control; read data at cycle N+1 for a grant at cycle N.
- Back-to-back grants allowed every cycle. A read at N and a write at N+1 are both legal. rvalid for N appears at N+1 regardless of the access at N+1.
- Requests are level-held. A requester keeps req and payload stable until it sees gnt. Dropping req before gnt cancels the request with no side effects.
- Worst case E wait with P requesting continuously: STARVE_LIMIT cycles, then grant in the E_PRI cycle. P stalls for exactly that one cycle.
- Reset values:
  - All gnt/rvalid/stall outputs are 0.
  - rdata registers are 0.
  - FSM is in P_PRI; wait_cnt is 0.
  - dm_* outputs are 0.
  - Mirror (if compiled in) is 0.
- Reset asserted while a read is in flight discards the pending rvalid. Requests are ignored during the reset cycle; p_stall=0 while sys_rst=1.

## Configuration
- DMEM_ARB_VMEM_MIRROR_EN defined:
  - Adds output vmem_reg [63:0].
  - On any granted write with addr[12:3]==10'h3FF, each byte lane whose dm_wea bit is set updates from dm_dina.
  - The mirror updates in the grant cycle's clock edge, in parallel with the dmem write.
- Undefined: no vmem_reg port and no mirror logic; all other behaviour is identical.

## Test plan
- Reset: hold sys_rst 2 cycles with both ports requesting -> all gnt/rvalid/stall=0, dm_ena=0. The first cycle after release grants P.
- P write then read:
  - Stimulus: p_we=1, p_addr=0x012, p_width=0x03, p_wdata=0x0000_0000_00AB_0000 -> dm_wea=0x0C, dm_addra=2.
  - Next cycle: read of 0x010 -> p_rvalid the cycle after, with p_rdata=0x0000_0000_00AB_0000.
- Contention: p_req and e_req held continuously, STARVE_LIMIT=4:
  - P is granted cycles 0-3; E is granted in cycle 4 with p_stall=1 in cycle 4.
  - P is granted again from cycle 5; the pattern repeats every 5 cycles.
- Read tag routing: P reads word 5 at N, E reads word 6 at N+1 -> p_rvalid at N+1 with word 5, e_rvalid at N+2 with word 6. The other port's rvalid stays 0.
- Mid-flight reset: grant a P read at N and assert sys_rst at N+1 -> p_rvalid=0 at N+1, FSM in P_PRI, wait_cnt=0.
- Mirror (DMEM_ARB_VMEM_MIRROR_EN): E writes 0x1FF8 with e_width=0xFF and data 0x1122334455667788 -> vmem_reg=0x1122334455667788. A write to 0x1FF0 leaves vmem_reg unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single 1024 x 64-bit data memory port between the pipeline
//   mem stage (port P) and an external requester (port E). P normally has
//   priority. A wait counter grants E one forced-priority cycle after it has
//   waited STARVE_LIMIT cycles. Read data returns one cycle after the grant
//   and is routed to the port that issued the read.
//
//   Handshake: req and its payload are level-held until gnt is seen. gnt is
//   combinational in the access cycle. Dropping req before gnt cancels the
//   access. rvalid pulses exactly one cycle after a granted read.
//
// Ports
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   p_* / e_*                pipeline / external request and response ports
//   p_stall                  p_req && !p_gnt (0 while in reset)
//   dm_*                     dmem port (ena, byte wea, word addr, din, dout)
//   dbg_state                priority FSM state (0 = P_PRI, 1 = E_PRI)
//   dbg_wait_cnt             E starvation wait counter
//   vmem_reg                 last-word mirror, present only when
//                            DMEM_ARB_VMEM_MIRROR_EN is defined
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [12:0] p_addr,
  input  logic [7:0]  p_width,
  input  logic [63:0] p_wdata,
  output logic        p_stall,
  output logic        p_gnt,
  output logic        p_rvalid,
  output logic [63:0] p_rdata,
  input  logic        e_req,
  input  logic        e_we,
  input  logic [12:0] e_addr,
  input  logic [7:0]  e_width,
  input  logic [63:0] e_wdata,
  output logic        e_gnt,
  output logic        e_rvalid,
  output logic [63:0] e_rdata,
  output logic        dm_ena,
  output logic [7:0]  dm_wea,
  output logic [9:0]  dm_addra,
  output logic [63:0] dm_dina,
  input  logic [63:0] dm_douta,
  output logic        dbg_state,
`ifdef DMEM_ARB_VMEM_MIRROR_EN
  output logic [63:0] vmem_reg,
`endif
  output logic [3:0]  dbg_wait_cnt
);

  typedef enum logic {
    P_PRI = 1'b0,
    E_PRI = 1'b1
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  wait_inc;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_tag_q, rd_tag_d;   // 1 = read belongs to port E
  logic [63:0] p_rdata_q, p_rdata_d;
  logic [63:0] e_rdata_q, e_rdata_d;
  logic [7:0]  p_mask, e_mask;

  // Grant and dmem drive
  always_comb begin
    p_gnt = 1'b0;
    e_gnt = 1'b0;
    if (!sys_rst) begin
      if (state_q == E_PRI) begin
        if (e_req)      e_gnt = 1'b1;
        else if (p_req) p_gnt = 1'b1;
      end else begin
        if (p_req)      p_gnt = 1'b1;
        else if (e_req) e_gnt = 1'b1;
      end
    end
    p_stall = p_req && !p_gnt && !sys_rst;

    // Shift result is 8 bits wide, so lanes shifted past bit 7 are dropped.
    p_mask = p_width << p_addr[2:0];
    e_mask = e_width << e_addr[2:0];

    dm_ena   = 1'b0;
    dm_wea   = 8'h00;
    dm_addra = 10'h000;
    dm_dina  = 64'h0;
    if (p_gnt) begin
      dm_ena   = 1'b1;
      dm_wea   = p_we ? p_mask : 8'h00;
      dm_addra = p_addr[12:3];
      dm_dina  = p_wdata;
    end else if (e_gnt) begin
      dm_ena   = 1'b1;
      dm_wea   = e_we ? e_mask : 8'h00;
      dm_addra = e_addr[12:3];
      dm_dina  = e_wdata;
    end
  end

  // Priority FSM and starvation counter
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wait_inc   = wait_cnt_q + 4'd1;
    if (state_q == E_PRI) begin
      state_d    = P_PRI;
      wait_cnt_d = 4'd0;
    end else if (e_req && !e_gnt) begin
      wait_cnt_d = wait_inc;
      if (wait_inc == LIMIT) state_d = E_PRI;
    end else begin
      wait_cnt_d = 4'd0;
    end
  end

  // Read return path: tag the read at grant, route dmem data next cycle.
  always_comb begin
    rd_valid_d = (p_gnt && !p_we) || (e_gnt && !e_we);
    rd_tag_d   = e_gnt;
    // A pending read is dropped if reset arrives before its data returns.
    p_rvalid   = rd_valid_q && !rd_tag_q && !sys_rst;
    e_rvalid   = rd_valid_q && rd_tag_q && !sys_rst;
    p_rdata_d  = p_rvalid ? dm_douta : p_rdata_q;
    e_rdata_d  = e_rvalid ? dm_douta : e_rdata_q;
    p_rdata    = p_rdata_d;
    e_rdata    = e_rdata_d;
  end

`ifdef DMEM_ARB_VMEM_MIRROR_EN
  logic [63:0] vmem_q, vmem_d;

  // Mirror of the top dmem word, byte-lane updated with the dmem write.
  always_comb begin
    vmem_d = vmem_q;
    if (dm_ena && (dm_addra == 10'h3FF)) begin
      for (int i = 0; i < 8; i++) begin
        if (dm_wea[i]) vmem_d[8*i +: 8] = dm_dina[8*i +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) vmem_q <= 64'h0;
    else         vmem_q <= vmem_d;
  end

  assign vmem_reg = vmem_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= P_PRI;
      wait_cnt_q <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= 1'b0;
      p_rdata_q  <= 64'h0;
      e_rdata_q  <= 64'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      p_rdata_q  <= p_rdata_d;
      e_rdata_q  <= e_rdata_d;
    end
  end

  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Bench for dmem_arbiter. Holds a behavioural 1024 x 64 dmem on the dm_*
//   port and a separate reference image used to predict read data. Each
//   driven cycle states which port should win; read expectations are queued
//   with their due cycle and popped when rvalid is sampled.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        p_req, p_we, e_req, e_we;
  logic [12:0] p_addr, e_addr;
  logic [7:0]  p_width, e_width;
  logic [63:0] p_wdata, e_wdata;
  logic        p_stall, p_gnt, p_rvalid, e_gnt, e_rvalid;
  logic [63:0] p_rdata, e_rdata;
  logic        dm_ena;
  logic [7:0]  dm_wea;
  logic [9:0]  dm_addra;
  logic [63:0] dm_dina;
  logic [63:0] dm_douta = 64'h0;
  logic        dbg_state;
  logic [3:0]  dbg_wait_cnt;
`ifdef DMEM_ARB_VMEM_MIRROR_EN
  logic [63:0] vmem_reg;
`endif

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_width(p_width),
    .p_wdata(p_wdata), .p_stall(p_stall), .p_gnt(p_gnt),
    .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_width(e_width),
    .e_wdata(e_wdata), .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .dm_ena(dm_ena), .dm_wea(dm_wea), .dm_addra(dm_addra),
    .dm_dina(dm_dina), .dm_douta(dm_douta),
    .dbg_state(dbg_state),
`ifdef DMEM_ARB_VMEM_MIRROR_EN
    .vmem_reg(vmem_reg),
`endif
    .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural dmem: read-first, 1-cycle read latency.
  logic [63:0] mem [1024];
  always @(posedge clk) begin
    if (dm_ena) begin
      dm_douta <= mem[dm_addra];
      for (int i = 0; i < 8; i++)
        if (dm_wea[i]) mem[dm_addra][8*i +: 8] <= dm_dina[8*i +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] ref_mem [1024];
  logic [63:0] exp_p_q[$];
  logic [63:0] exp_e_q[$];
  int          due_p_q[$];
  int          due_e_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected byte enables built lane by lane.
  function automatic logic [7:0] exp_wea(input logic we, input logic [7:0] w,
                                         input logic [2:0] off);
    logic [7:0] r;
    r = 8'h00;
    if (we)
      for (int i = 0; i < 8; i++)
        if (i >= int'(off)) r[i] = w[i - int'(off)];
    return r;
  endfunction

  // Read-return monitor.
  always @(negedge clk) begin
    if (due_p_q.size() != 0 && due_p_q[0] == cyc) begin
      check_eq("p_rvalid", {63'h0, p_rvalid}, 64'h1);
      check_eq("p_rdata", p_rdata, exp_p_q[0]);
      void'(due_p_q.pop_front());
      void'(exp_p_q.pop_front());
    end else begin
      check_eq("p_rvalid_idle", {63'h0, p_rvalid}, 64'h0);
    end
    if (due_e_q.size() != 0 && due_e_q[0] == cyc) begin
      check_eq("e_rvalid", {63'h0, e_rvalid}, 64'h1);
      check_eq("e_rdata", e_rdata, exp_e_q[0]);
      void'(due_e_q.pop_front());
      void'(exp_e_q.pop_front());
    end else begin
      check_eq("e_rvalid_idle", {63'h0, e_rvalid}, 64'h0);
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle with inputs already driven; ep/ee name the expected winner.
  task automatic step(input logic ep, input logic ee);
    logic        we;
    logic [12:0] a;
    logic [7:0]  w, m;
    logic [63:0] d;
    @(negedge clk);
    check_eq("p_gnt", {63'h0, p_gnt}, {63'h0, ep});
    check_eq("e_gnt", {63'h0, e_gnt}, {63'h0, ee});
    check_eq("p_stall", {63'h0, p_stall}, {63'h0, p_req && !ep && !sys_rst});
    if (ep || ee) begin
      we = ep ? p_we    : e_we;
      a  = ep ? p_addr  : e_addr;
      w  = ep ? p_width : e_width;
      d  = ep ? p_wdata : e_wdata;
      m  = exp_wea(we, w, a[2:0]);
      check_eq("dm_ena", {63'h0, dm_ena}, 64'h1);
      check_eq("dm_addra", {54'h0, dm_addra}, {54'h0, a[12:3]});
      check_eq("dm_wea", {56'h0, dm_wea}, {56'h0, m});
      if (we) begin
        check_eq("dm_dina", dm_dina, d);
        for (int i = 0; i < 8; i++)
          if (m[i]) ref_mem[a[12:3]][8*i +: 8] = d[8*i +: 8];
      end else if (ep) begin
        exp_p_q.push_back(ref_mem[a[12:3]]);
        due_p_q.push_back(cyc + 1);
      end else begin
        exp_e_q.push_back(ref_mem[a[12:3]]);
        due_e_q.push_back(cyc + 1);
      end
    end else begin
      check_eq("dm_idle", {dm_ena, dm_wea, dm_addra, 45'h0} | dm_dina, 64'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic set_p(input logic req, input logic we, input logic [12:0] a,
                       input logic [7:0] w, input logic [63:0] d);
    p_req = req; p_we = we; p_addr = a; p_width = w; p_wdata = d;
  endtask

  task automatic set_e(input logic req, input logic we, input logic [12:0] a,
                       input logic [7:0] w, input logic [63:0] d);
    e_req = req; e_we = we; e_addr = a; e_width = w; e_wdata = d;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] wtab [4];
  initial begin
    logic [63:0] w5;
    logic        pick_e;
    logic [12:0] ra;
    logic [7:0]  rw;
    logic        rwe;
    logic [63:0] rd;
    wtab[0] = 8'h01; wtab[1] = 8'h03; wtab[2] = 8'h0F; wtab[3] = 8'hFF;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 64'h0;
      ref_mem[i] = 64'h0;
    end

    // Reset with both ports requesting.
    sys_rst = 1'b1;
    set_p(1'b1, 1'b0, 13'h000, 8'hFF, 64'h0);
    set_e(1'b1, 1'b0, 13'h008, 8'hFF, 64'h0);
    @(posedge clk); #1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("rst_state", {63'h0, dbg_state}, 64'h0);
    check_eq("rst_wait_cnt", {60'h0, dbg_wait_cnt}, 64'h0);
    check_eq("rst_p_rdata", p_rdata, 64'h0);
    check_eq("rst_e_rdata", e_rdata, 64'h0);
`ifdef DMEM_ARB_VMEM_MIRROR_EN
    check_eq("rst_vmem", vmem_reg, 64'h0);
`endif
    sys_rst = 1'b0;
    step(1'b1, 1'b0);              // first cycle after release grants P
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    step(1'b0, 1'b0);

    // P write then read back.
    set_p(1'b1, 1'b1, 13'h012, 8'h03, 64'h0000_0000_00AB_0000);
    @(negedge clk);
    check_eq("tp_wea", {56'h0, dm_wea}, 64'h0C);
    check_eq("tp_addra", {54'h0, dm_addra}, 64'h2);
    @(posedge clk); #1;
    ref_mem[2][23:16] = 8'hAB;
    set_p(1'b1, 1'b0, 13'h010, 8'hFF, 64'h0);
    step(1'b1, 1'b0);
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    step(1'b0, 1'b0);
    check_eq("tp_rdata_val", p_rdata, 64'h0000_0000_00AB_0000);

    // Misaligned mask truncates rather than wraps.
    set_p(1'b1, 1'b1, 13'h00D, 8'hFF, 64'h0102_0304_0506_0708);
    step(1'b1, 1'b0);
    set_p(1'b1, 1'b1, 13'h00F, 8'h03, 64'hF0F0_F0F0_F0F0_F0F0);
    step(1'b1, 1'b0);

    // Random single-port traffic.
    for (int k = 0; k < 24; k++) begin
      pick_e = 1'($urandom_range(0, 1));
      ra  = {6'h0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
      rw  = wtab[$urandom_range(0, 3)];
      rwe = 1'($urandom_range(0, 1));
      rd  = {$urandom, $urandom};
      if (pick_e) begin
        set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
        set_e(1'b1, rwe, ra, rw, rd);
      end else begin
        set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
        set_p(1'b1, rwe, ra, rw, rd);
      end
      step(!pick_e, pick_e);
    end
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    step(1'b0, 1'b0);

    // Preload words 5 and 6.
    set_p(1'b1, 1'b1, 13'h028, 8'hFF, 64'hA5A5_0005_DEAD_0005);
    step(1'b1, 1'b0);
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    set_e(1'b1, 1'b1, 13'h030, 8'hFF, 64'h5A5A_0006_BEEF_0006);
    step(1'b0, 1'b1);
    set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    step(1'b0, 1'b0);

    // Contention: E forced in every (LIM+1)th cycle.
    set_p(1'b1, 1'b0, 13'h028, 8'hFF, 64'h0);
    set_e(1'b1, 1'b0, 13'h030, 8'hFF, 64'h0);
    for (int k = 0; k < 3 * (LIM + 1); k++) begin
      step((k % (LIM + 1)) != LIM, (k % (LIM + 1)) == LIM);
      check_eq("cont_state", {63'h0, dbg_state},
               {63'h0, ((k + 1) % (LIM + 1)) == LIM});
    end
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    step(1'b0, 1'b0);

    // Read tag routing: P word 5 at N, E word 6 at N+1.
    w5 = ref_mem[5];
    set_p(1'b1, 1'b0, 13'h028, 8'hFF, 64'h0);
    step(1'b1, 1'b0);
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    set_e(1'b1, 1'b0, 13'h030, 8'hFF, 64'h0);
    step(1'b0, 1'b1);
    set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    check_eq("p_rdata_hold", p_rdata, w5);
    step(1'b0, 1'b0);
    check_eq("p_rdata_hold2", p_rdata, w5);

    // Mid-flight reset discards the pending read.
    set_p(1'b1, 1'b0, 13'h030, 8'hFF, 64'h0);
    set_e(1'b1, 1'b0, 13'h028, 8'hFF, 64'h0);
    step(1'b1, 1'b0);
    void'(exp_p_q.pop_back());
    void'(due_p_q.pop_back());
    check_eq("mf_wait_cnt_pre", {60'h0, dbg_wait_cnt}, 64'h1);
    sys_rst = 1'b1;
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    @(negedge clk);
    check_eq("mf_p_rvalid", {63'h0, p_rvalid}, 64'h0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    check_eq("mf_state", {63'h0, dbg_state}, 64'h0);
    check_eq("mf_wait_cnt", {60'h0, dbg_wait_cnt}, 64'h0);
    step(1'b0, 1'b0);

`ifdef DMEM_ARB_VMEM_MIRROR_EN
    // Mirror of the top word.
    set_e(1'b1, 1'b1, 13'h1FF8, 8'hFF, 64'h1122_3344_5566_7788);
    step(1'b0, 1'b1);
    check_eq("vmem_full", vmem_reg, 64'h1122_3344_5566_7788);
    set_e(1'b1, 1'b1, 13'h1FF0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b1);
    check_eq("vmem_other", vmem_reg, 64'h1122_3344_5566_7788);
    set_e(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
    set_p(1'b1, 1'b1, 13'h1FFA, 8'h01, 64'h0000_0000_00EE_0000);
    step(1'b1, 1'b0);
    check_eq("vmem_lane", vmem_reg, 64'h1122_3344_55EE_7788);
    set_p(1'b0, 1'b0, 13'h0, 8'h0, 64'h0);
`endif

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("p_q_drained", 64'(exp_p_q.size()), 64'h0);
    check_eq("e_q_drained", 64'(exp_e_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
